// File: rtl/ultrasonic_echo_gen_if.sv
`default_nettype none
// ------------------------------------------------------------------------
// ultrasonic_echo_gen_if : trigger / distance / echo signal bundle.  Rev 1.0
// ------------------------------------------------------------------------
interface ultrasonic_echo_gen_if;
  logic        trigger;
  logic        en;
  logic [19:0] dist_cm;
  logic        dur;
  logic        busy;
  logic        short_trig;

  modport master (
    output trigger,
    output en,
    output dist_cm,
    input  dur,
    input  busy,
    input  short_trig
  );

  modport slave (
    input  trigger,
    input  en,
    input  dist_cm,
    output dur,
    output busy,
    output short_trig
  );
endinterface
`default_nettype wire

// File: rtl/ultrasonic_echo_gen.sv
`default_nettype none
// ------------------------------------------------------------------------
// ultrasonic_echo_gen : ranging-sensor echo emulator (trigger in, echo out). Rev 1.0
// ------------------------------------------------------------------------
module ultrasonic_echo_gen #(
  parameter int CLK_PER_US  = 50,
  parameter int TRIG_MIN_US = 10,
  parameter int BURST_US    = 200,
  parameter int US_PER_CM   = 58,
  parameter int MIN_CM      = 2,
  parameter int MAX_CM      = 400,
  parameter int TIMEOUT_US  = 38000,
  parameter int HOLDOFF_US  = 10000
) (
  input  logic                  clk,
  input  logic                  rst,
  ultrasonic_echo_gen_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_TRIG_HI = 3'd1,
    S_BURST   = 3'd2,
    S_ECHO    = 3'd3,
    S_HOLDOFF = 3'd4
  } state_t;

  localparam int              PW            = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
  localparam logic [PW-1:0]   PRE_MAX       = PW'(CLK_PER_US - 1);
  localparam logic [15:0]     TRIG_MIN_CYC  = 16'(TRIG_MIN_US * CLK_PER_US);
  localparam logic [15:0]     BURST_LAST    = 16'(BURST_US - 1);
  localparam logic [15:0]     HOLDOFF_LAST  = 16'(HOLDOFF_US - 1);
  localparam logic [15:0]     WIDTH_MIN     = 16'(MIN_CM * US_PER_CM);
  localparam logic [15:0]     WIDTH_TIMEOUT = 16'(TIMEOUT_US);
  localparam logic [31:0]     MIN_CM_W      = 32'(MIN_CM);
  localparam logic [31:0]     MAX_CM_W      = 32'(MAX_CM);
  localparam logic [31:0]     US_PER_CM_W   = 32'(US_PER_CM);

  state_t          state_q, state_d;
  logic [1:0]      trig_sync_q, trig_sync_d;
  logic [1:0]      sync_vld_q, sync_vld_d;
  logic            trig_low_q, trig_low_d;
  logic [15:0]     hi_cnt_q, hi_cnt_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [15:0]     us_cnt_q, us_cnt_d;
  logic [19:0]     dist_q, dist_d;
  logic            dur_q, dur_d;
  logic            busy_q, busy_d;
  logic            short_trig_q, short_trig_d;

  logic            trig_s;
  logic            us_tick;
  logic [31:0]     dist_ext;
  logic [15:0]     width_us;
  logic [15:0]     phase_last;
  state_t          phase_next;

  assign trig_s  = trig_sync_q[1];
  assign us_tick = (presc_q == PRE_MAX);

  // Echo width in microseconds, clamped to the near limit or the no-object timeout.
  always_comb begin
    dist_ext = {12'd0, dist_q};
    if (dist_ext < MIN_CM_W) begin
      width_us = WIDTH_MIN;
    end else if (dist_ext > MAX_CM_W) begin
      width_us = WIDTH_TIMEOUT;
    end else begin
      width_us = 16'(dist_ext * US_PER_CM_W);
    end
  end

  always_comb begin
    state_d      = state_q;
    trig_sync_d  = {trig_sync_q[0], bus.trigger};
    sync_vld_d   = {sync_vld_q[0], 1'b1};
    // Only a genuinely sampled low arms edge detection, so a trigger high at reset release is ignored.
    trig_low_d   = ~trig_s & sync_vld_q[1];
    hi_cnt_d     = hi_cnt_q;
    presc_d      = presc_q;
    us_cnt_d     = us_cnt_q;
    dist_d       = dist_q;
    short_trig_d = 1'b0;
    phase_last   = 16'd0;
    phase_next   = S_IDLE;

    case (state_q)
      S_IDLE: begin
        presc_d  = '0;
        us_cnt_d = 16'd0;
        if (trig_s && trig_low_q && bus.en) begin
          state_d  = S_TRIG_HI;
          hi_cnt_d = 16'd0;
        end
      end
      S_TRIG_HI: begin
        if (trig_s) begin
          if (hi_cnt_q != TRIG_MIN_CYC) begin
            hi_cnt_d = hi_cnt_q + 16'd1;
          end
        end else if (hi_cnt_q >= TRIG_MIN_CYC - 16'd1) begin
          // The rise cycle itself is not in hi_cnt, hence the minus one.
          dist_d   = bus.dist_cm;
          presc_d  = '0;
          us_cnt_d = 16'd0;
          state_d  = S_BURST;
        end else begin
          short_trig_d = 1'b1;
          state_d      = S_IDLE;
        end
      end
      S_BURST: begin
        phase_last = BURST_LAST;
        phase_next = S_ECHO;
      end
      S_ECHO: begin
        phase_last = width_us - 16'd1;
        phase_next = S_HOLDOFF;
      end
      S_HOLDOFF: begin
        phase_last = HOLDOFF_LAST;
        phase_next = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (state_q inside {S_BURST, S_ECHO, S_HOLDOFF}) begin
      if (us_tick) begin
        presc_d = '0;
        if (us_cnt_q == phase_last) begin
          us_cnt_d = 16'd0;
          state_d  = phase_next;
        end else begin
          us_cnt_d = us_cnt_q + 16'd1;
        end
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end

    dur_d  = (state_d == S_ECHO);
    busy_d = (state_d inside {S_BURST, S_ECHO, S_HOLDOFF});
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      trig_sync_q  <= 2'b00;
      sync_vld_q   <= 2'b00;
      trig_low_q   <= 1'b0;
      hi_cnt_q     <= 16'd0;
      presc_q      <= '0;
      us_cnt_q     <= 16'd0;
      dist_q       <= 20'd0;
      dur_q        <= 1'b0;
      busy_q       <= 1'b0;
      short_trig_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      trig_sync_q  <= trig_sync_d;
      sync_vld_q   <= sync_vld_d;
      trig_low_q   <= trig_low_d;
      hi_cnt_q     <= hi_cnt_d;
      presc_q      <= presc_d;
      us_cnt_q     <= us_cnt_d;
      dist_q       <= dist_d;
      dur_q        <= dur_d;
      busy_q       <= busy_d;
      short_trig_q <= short_trig_d;
    end
  end

  assign bus.dur        = dur_q;
  assign bus.busy       = busy_q;
  assign bus.short_trig = short_trig_q;

  a_dur_implies_busy: assert property (@(posedge clk) disable iff (!rst) dur_q |-> busy_q);
  a_short_not_busy:   assert property (@(posedge clk) disable iff (!rst) short_trig_q |-> !busy_q);

endmodule
`default_nettype wire

// File: tb/tb_ultrasonic_echo_gen.sv
`default_nettype none
// ------------------------------------------------------------------------
// tb_ultrasonic_echo_gen : directed bench with scaled timing parameters. Rev 1.0
// ------------------------------------------------------------------------
module tb_ultrasonic_echo_gen;

  // Scaled: 4 clk/us, 12-cycle min trigger, 20-cycle burst, 3 us/cm, 40-cycle holdoff
  localparam int LATENCY = 23;   // 2 sync + 1 + 20 burst cycles
  localparam int HOLDOFF = 40;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests = 0;
  int   fails = 0;
  int   short_cnt = 0;
  int   rise_cnt = 0;
  int   busy_cnt = 0;
  logic dur_prev = 1'b0;

  ultrasonic_echo_gen_if bus ();

  ultrasonic_echo_gen #(
    .CLK_PER_US (4),
    .TRIG_MIN_US(3),
    .BURST_US   (5),
    .US_PER_CM  (3),
    .MIN_CM     (2),
    .MAX_CM     (400),
    .TIMEOUT_US (1300),
    .HOLDOFF_US (10)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.short_trig === 1'b1) short_cnt++;
    if (bus.busy === 1'b1) busy_cnt++;
    if (bus.dur === 1'b1 && dur_prev !== 1'b1) rise_cnt++;
    dur_prev = bus.dur;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic settle(input int c);
    repeat (c) @(posedge clk);
    #1;
  endtask

  task automatic pulse_trigger(input int cyc);
    @(posedge clk);
    #1 bus.trigger = 1'b1;
    repeat (cyc) @(posedge clk);
    #1 bus.trigger = 1'b0;
  endtask

  task automatic wait_dur(input logic val, input int bound, output int n);
    int  k = 0;
    bit  hit = 1'b0;
    while (!hit && k < bound) begin
      @(posedge clk);
      k++;
      @(negedge clk);
      if (bus.dur === val) hit = 1'b1;
    end
    n = hit ? k : -1;
  endtask

  task automatic wait_busy(input logic val, input int bound, output int n);
    int  k = 0;
    bit  hit = 1'b0;
    while (!hit && k < bound) begin
      @(posedge clk);
      k++;
      @(negedge clk);
      if (bus.busy === val) hit = 1'b1;
    end
    n = hit ? k : -1;
  endtask

  task automatic test_reset();
    bus.trigger = 1'b0;
    bus.en      = 1'b1;
    bus.dist_cm = 20'd0;
    rst         = 1'b0;
    repeat (3) @(negedge clk);
    tests++; if (bus.dur !== 1'b0) begin fails++; $display("FAIL reset_dur: got %b expected 0", bus.dur); end
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    tests++; if (bus.short_trig !== 1'b0) begin fails++; $display("FAIL reset_short: got %b expected 0", bus.short_trig); end
    rst = 1'b1;
    settle(5);
  endtask

  task automatic test_basic();
    int n;
    bus.dist_cm = 20'd100;
    pulse_trigger(16);
    wait_dur(1'b1, 100, n);
    tests++; if (n != LATENCY) begin fails++; $display("FAIL basic_latency: got %0d expected %0d", n, LATENCY); end
    tests++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL basic_busy: got %b expected 1", bus.busy); end
    wait_dur(1'b0, 6000, n);
    tests++; if (n != 1200) begin fails++; $display("FAIL basic_width: got %0d expected 1200", n); end
    wait_busy(1'b0, 200, n);
    tests++; if (n != HOLDOFF) begin fails++; $display("FAIL basic_holdoff: got %0d expected %0d", n, HOLDOFF); end
  endtask

  task automatic test_short_trig();
    int n, s0, r0, b0;
    s0 = short_cnt; r0 = rise_cnt; b0 = busy_cnt;
    pulse_trigger(8);
    settle(10);
    tests++; if (short_cnt - s0 != 1) begin fails++; $display("FAIL short_pulse8: got %0d expected 1", short_cnt - s0); end
    pulse_trigger(11);
    settle(10);
    tests++; if (short_cnt - s0 != 2) begin fails++; $display("FAIL short_pulse11: got %0d expected 2", short_cnt - s0); end
    tests++; if (rise_cnt - r0 != 0) begin fails++; $display("FAIL short_no_dur: got %0d expected 0", rise_cnt - r0); end
    tests++; if (busy_cnt - b0 != 0) begin fails++; $display("FAIL short_no_busy: got %0d expected 0", busy_cnt - b0); end
    bus.dist_cm = 20'd2;
    pulse_trigger(12);
    wait_dur(1'b1, 100, n);
    tests++; if (n != LATENCY) begin fails++; $display("FAIL min_trig_latency: got %0d expected %0d", n, LATENCY); end
    wait_dur(1'b0, 6000, n);
    tests++; if (n != 24) begin fails++; $display("FAIL min_trig_width: got %0d expected 24", n); end
    tests++; if (short_cnt - s0 != 2) begin fails++; $display("FAIL min_trig_short: got %0d expected 2", short_cnt - s0); end
    wait_busy(1'b0, 200, n);
  endtask

  task automatic test_boundaries();
    logic [19:0] dists [6];
    int          widths [6];
    int          n;
    dists  = '{20'd0, 20'd1, 20'd3, 20'd400, 20'd401, 20'hFFFFF};
    widths = '{24, 24, 36, 4800, 5200, 5200};
    for (int i = 0; i < 6; i++) begin
      bus.dist_cm = dists[i];
      pulse_trigger(12);
      wait_dur(1'b1, 100, n);
      tests++; if (n != LATENCY) begin fails++; $display("FAIL bound_latency[%0d]: got %0d expected %0d", i, n, LATENCY); end
      wait_dur(1'b0, 6000, n);
      tests++; if (n != widths[i]) begin fails++; $display("FAIL bound_width dist=%0d: got %0d expected %0d", dists[i], n, widths[i]); end
      wait_busy(1'b0, 200, n);
      tests++; if (n != HOLDOFF) begin fails++; $display("FAIL bound_holdoff[%0d]: got %0d expected %0d", i, n, HOLDOFF); end
    end
  endtask

  task automatic test_back_to_back();
    int n, nb, s0, r0;
    s0 = short_cnt; r0 = rise_cnt;
    bus.dist_cm = 20'd50;
    pulse_trigger(16);
    settle(3);
    bus.dist_cm = 20'd300;
    wait_dur(1'b1, 100, n);
    fork
      wait_dur(1'b0, 6000, n);
      begin settle(50); pulse_trigger(16); end
    join
    tests++; if (n != 600) begin fails++; $display("FAIL ignore_width: got %0d expected 600", n); end
    fork
      wait_busy(1'b0, 200, nb);
      pulse_trigger(16);
    join
    tests++; if (nb != HOLDOFF) begin fails++; $display("FAIL ignore_holdoff: got %0d expected %0d", nb, HOLDOFF); end
    settle(100);
    tests++; if (rise_cnt - r0 != 1) begin fails++; $display("FAIL ignore_single_echo: got %0d expected 1", rise_cnt - r0); end
    tests++; if (short_cnt - s0 != 0) begin fails++; $display("FAIL ignore_short: got %0d expected 0", short_cnt - s0); end
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL ignore_idle_busy: got %b expected 0", bus.busy); end
  endtask

  task automatic test_reset_mid_echo();
    int n, r0, s0;
    bus.dist_cm = 20'd100;
    pulse_trigger(12);
    wait_dur(1'b1, 100, n);
    settle(100);
    r0 = rise_cnt; s0 = short_cnt;
    @(negedge clk);
    #1 rst = 1'b0;
    #1;
    tests++; if (bus.dur !== 1'b0) begin fails++; $display("FAIL rst_async_dur: got %b expected 0", bus.dur); end
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL rst_async_busy: got %b expected 0", bus.busy); end
    bus.trigger = 1'b1;
    settle(3);
    @(negedge clk);
    rst = 1'b1;
    settle(30);
    bus.trigger = 1'b0;
    settle(100);
    tests++; if (rise_cnt - r0 != 0) begin fails++; $display("FAIL rst_held_trig_dur: got %0d expected 0", rise_cnt - r0); end
    tests++; if (short_cnt - s0 != 0) begin fails++; $display("FAIL rst_held_trig_short: got %0d expected 0", short_cnt - s0); end
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL rst_held_trig_busy: got %b expected 0", bus.busy); end
    bus.dist_cm = 20'd2;
    pulse_trigger(12);
    wait_dur(1'b1, 100, n);
    tests++; if (n != LATENCY) begin fails++; $display("FAIL rst_fresh_latency: got %0d expected %0d", n, LATENCY); end
    wait_dur(1'b0, 6000, n);
    tests++; if (n != 24) begin fails++; $display("FAIL rst_fresh_width: got %0d expected 24", n); end
    wait_busy(1'b0, 200, n);
  endtask

  task automatic test_enable();
    int n, r0, b0, s0;
    r0 = rise_cnt; b0 = busy_cnt; s0 = short_cnt;
    bus.en      = 1'b0;
    bus.dist_cm = 20'd2;
    pulse_trigger(12);
    settle(60);
    tests++; if (rise_cnt - r0 != 0) begin fails++; $display("FAIL en_low_dur: got %0d expected 0", rise_cnt - r0); end
    tests++; if (busy_cnt - b0 != 0) begin fails++; $display("FAIL en_low_busy: got %0d expected 0", busy_cnt - b0); end
    tests++; if (short_cnt - s0 != 0) begin fails++; $display("FAIL en_low_short: got %0d expected 0", short_cnt - s0); end
    bus.en = 1'b1;
    pulse_trigger(12);
    settle(5);
    bus.en = 1'b0;
    wait_dur(1'b1, 100, n);
    tests++; if (n != LATENCY - 5) begin fails++; $display("FAIL en_drop_latency: got %0d expected %0d", n, LATENCY - 5); end
    wait_dur(1'b0, 6000, n);
    tests++; if (n != 24) begin fails++; $display("FAIL en_drop_width: got %0d expected 24", n); end
    wait_busy(1'b0, 200, n);
    tests++; if (n != HOLDOFF) begin fails++; $display("FAIL en_drop_holdoff: got %0d expected %0d", n, HOLDOFF); end
    bus.en = 1'b1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_short_trig();
    test_boundaries();
    test_back_to_back();
    test_reset_mid_echo();
    test_enable();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
